// File: rtl/gcd_stream_unit.sv
`default_nettype none
// ============================================================================
// Module      : gcd_stream_unit
// Description : Streaming GCD accelerator. Operands arrive on independent A/B
//               valid/ready streams, are buffered, paired in arrival order and
//               reduced by a subtract-and-compare engine (one step per cycle).
//               Results leave in pair order through a first-word fall-through
//               valid/ready output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_stream_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  input  logic             y_ready_i,
  output logic             busy_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] a_mem_q [DEPTH];
  logic [WIDTH-1:0] b_mem_q [DEPTH];
  logic [WIDTH-1:0] y_mem_q [DEPTH];
  logic [AW-1:0]    a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [AW-1:0]    b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [AW-1:0]    y_wr_q, y_wr_d, y_rd_q, y_rd_d;
  logic [AW:0]      a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, y_cnt_q, y_cnt_d;

  // Engine state
  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d;

  // Handshake qualifiers
  logic a_full, a_empty, b_full, b_empty, y_full, y_empty;
  logic a_push, b_push, eng_pop, y_push, y_pop;

  assign a_full  = (a_cnt_q == CNT_FULL);
  assign a_empty = (a_cnt_q == '0);
  assign b_full  = (b_cnt_q == CNT_FULL);
  assign b_empty = (b_cnt_q == '0);
  assign y_full  = (y_cnt_q == CNT_FULL);
  assign y_empty = (y_cnt_q == '0);

  // Ready comes from the registered count only, so a same-cycle pop on a full
  // FIFO never opens a write-through path.
  assign a_ready_o = !a_full;
  assign b_ready_o = !b_full;
  assign y_valid_o = !y_empty;
  assign y_data_o  = y_empty ? '0 : y_mem_q[y_rd_q];
  assign busy_o    = (state_q != ST_IDLE);

  assign a_push  = a_valid_i && !a_full;
  assign b_push  = b_valid_i && !b_full;
  assign eng_pop = (state_q == ST_IDLE) && !a_empty && !b_empty;
  assign y_push  = (state_q == ST_DONE) && !y_full;
  assign y_pop   = y_ready_i && !y_empty;

  // Pointer and occupancy update for all three FIFOs
  always_comb begin
    a_wr_d  = a_push  ? a_wr_q + PTR_ONE : a_wr_q;
    a_rd_d  = eng_pop ? a_rd_q + PTR_ONE : a_rd_q;
    b_wr_d  = b_push  ? b_wr_q + PTR_ONE : b_wr_q;
    b_rd_d  = eng_pop ? b_rd_q + PTR_ONE : b_rd_q;
    y_wr_d  = y_push  ? y_wr_q + PTR_ONE : y_wr_q;
    y_rd_d  = y_pop   ? y_rd_q + PTR_ONE : y_rd_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    y_cnt_d = y_cnt_q;
    case ({a_push, eng_pop})
      2'b10:   a_cnt_d = a_cnt_q + CNT_ONE;
      2'b01:   a_cnt_d = a_cnt_q - CNT_ONE;
      default: a_cnt_d = a_cnt_q;
    endcase
    case ({b_push, eng_pop})
      2'b10:   b_cnt_d = b_cnt_q + CNT_ONE;
      2'b01:   b_cnt_d = b_cnt_q - CNT_ONE;
      default: b_cnt_d = b_cnt_q;
    endcase
    case ({y_push, y_pop})
      2'b10:   y_cnt_d = y_cnt_q + CNT_ONE;
      2'b01:   y_cnt_d = y_cnt_q - CNT_ONE;
      default: y_cnt_d = y_cnt_q;
    endcase
  end

  // Engine next state: pair load, subtract-and-compare, result hand-off
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (eng_pop) begin
          ra_d    = a_mem_q[a_rd_q];
          rb_d    = b_mem_q[b_rd_q];
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Only the larger operand is reduced, so no step can underflow.
        if (ra_q == '0) begin
          res_d   = rb_q;
          state_d = ST_DONE;
        end else if (rb_q == '0) begin
          res_d   = ra_q;
          state_d = ST_DONE;
        end else if (ra_q == rb_q) begin
          res_d   = ra_q;
          state_d = ST_DONE;
        end else if (ra_q > rb_q) begin
          ra_d = ra_q - rb_q;
        end else begin
          rb_d = rb_q - ra_q;
        end
      end
      ST_DONE: begin
        if (!y_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_cnt_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
      y_wr_q  <= '0;
      y_rd_q  <= '0;
      y_cnt_q <= '0;
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
    end else begin
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      a_cnt_q <= a_cnt_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_cnt_q <= b_cnt_d;
      y_wr_q  <= y_wr_d;
      y_rd_q  <= y_rd_d;
      y_cnt_q <= y_cnt_d;
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
    end
  end

  // FIFO storage; contents are only visible through non-empty heads
  always_ff @(posedge clk_i) begin
    if (a_push) a_mem_q[a_wr_q] <= a_data_i;
    if (b_push) b_mem_q[b_wr_q] <= b_data_i;
    if (y_push) y_mem_q[y_wr_q] <= res_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_stream_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_stream_unit
// Description : Scoreboard bench for gcd_stream_unit with a Euclid reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_stream_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready_o;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready_o;
  logic             y_valid_o;
  logic [WIDTH-1:0] y_data_o;
  logic             y_ready = 1'b0;
  logic             busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int qa[$];
  int qb[$];
  int exp_q[$];
  bit rand_done = 1'b0;

  gcd_stream_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .a_valid_i (a_valid),
    .a_data_i  (a_data),
    .a_ready_o (a_ready_o),
    .b_valid_i (b_valid),
    .b_data_i  (b_data),
    .b_ready_o (b_ready_o),
    .y_valid_o (y_valid_o),
    .y_data_o  (y_data_o),
    .y_ready_i (y_ready),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  function automatic int gcd_ref(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: record accepted operands, pair them in order, queue the GCD
  always @(negedge clk) begin
    if (!rst_ni) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
    end else begin
      if (a_valid && a_ready_o) qa.push_back(int'(a_data));
      if (b_valid && b_ready_o) qb.push_back(int'(b_data));
      while (qa.size() > 0 && qb.size() > 0)
        exp_q.push_back(gcd_ref(qa.pop_front(), qb.pop_front()));
    end
  end

  // Monitor: every result transfer is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_ni && y_valid_o && y_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", int'(y_data_o), -1);
      else check("result", int'(y_data_o), exp_q.pop_front());
    end
  end

  // All drive tasks start and end at posedge+1
  task automatic send_a(input int v);
    bit rdy;
    int t = 0;
    a_valid = 1'b1;
    a_data  = WIDTH'(v);
    while (a_valid && t < 5000) begin
      @(negedge clk); rdy = a_ready_o;
      @(posedge clk); #1;
      if (rdy) a_valid = 1'b0;
      t++;
    end
    if (a_valid) begin
      check("send_a_timeout", 1, 0);
      a_valid = 1'b0;
    end
  endtask

  task automatic send_b(input int v);
    bit rdy;
    int t = 0;
    b_valid = 1'b1;
    b_data  = WIDTH'(v);
    while (b_valid && t < 5000) begin
      @(negedge clk); rdy = b_ready_o;
      @(posedge clk); #1;
      if (rdy) b_valid = 1'b0;
      t++;
    end
    if (b_valid) begin
      check("send_b_timeout", 1, 0);
      b_valid = 1'b0;
    end
  endtask

  task automatic send_pair(input int a, input int b);
    fork
      send_a(a);
      send_b(b);
    join
  endtask

  // Edges from the acceptance edge until y_valid_o is seen
  task automatic measure_latency(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!y_valid_o && n < 1000);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy_o || y_valid_o) && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_done", int'(exp_q.size() == 0 && !busy_o && !y_valid_o), 1);
  endtask

  task automatic offer_pair_now(input int a, input int b);
    a_valid = 1'b1; a_data = WIDTH'(a);
    b_valid = 1'b1; b_data = WIDTH'(b);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ready", int'(a_ready_o), 1);
    check("rst_b_ready", int'(b_ready_o), 1);
    check("rst_y_valid", int'(y_valid_o), 0);
    check("rst_y_data",  int'(y_data_o), 0);
    check("rst_busy",    int'(busy_o), 0);
    rst_ni = 1'b1;
    y_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a long computation
    offer_pair_now(255, 1);
    repeat (20) begin @(posedge clk); #1; end
    check("midcalc_busy", int'(busy_o), 1);
    #3 rst_ni = 1'b0;
    #1;
    check("arst_busy",    int'(busy_o), 0);
    check("arst_y_valid", int'(y_valid_o), 0);
    check("arst_a_ready", int'(a_ready_o), 1);
    check("arst_b_ready", int'(b_ready_o), 1);
    check("arst_y_data",  int'(y_data_o), 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (y_valid_o || busy_o) cnt++;
    end
    check("no_stale_after_reset", cnt, 0);

    // Single pairs with latency
    offer_pair_now(12, 8);
    measure_latency(n);
    check("lat_12_8", n, 5);
    drain();
    offer_pair_now(9, 9);
    measure_latency(n);
    check("lat_9_9", n, 3);
    drain();

    // Zero operands and worst-case step count
    send_pair(0, 7);
    send_pair(7, 0);
    send_pair(0, 0);
    drain();
    offer_pair_now(255, 1);
    measure_latency(n);
    check("lat_255_1", n, 257);
    drain();

    // Skewed streams
    send_a(6); send_a(15); send_a(35);
    send_b(4); send_b(10); send_b(21);
    drain();

    // Backpressure: Y full, engine parked in DONE, A/B full
    y_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH + 1; i++)
      send_pair($urandom_range(1, 20), $urandom_range(1, 20));
    repeat (30) begin @(posedge clk); #1; end
    check("bp_a_ready", int'(a_ready_o), 0);
    check("bp_b_ready", int'(b_ready_o), 0);
    check("bp_busy",    int'(busy_o), 1);
    check("bp_y_valid", int'(y_valid_o), 1);
    y_ready = 1'b1;
    drain();

    // Full A FIFO while the engine pops its head
    for (int i = 0; i < DEPTH; i++) send_a(30 + 10 * i);
    check("edge_a_full", int'(a_ready_o), 0);
    a_valid = 1'b1; a_data = 8'd70;
    b_valid = 1'b1; b_data = 8'd18;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("edge_ready_during_pop", int'(a_ready_o), 0);
    check("edge_idle_before_pop",  int'(busy_o), 0);
    @(posedge clk); #1;
    check("edge_ready_after_pop", int'(a_ready_o), 1);
    check("edge_busy_after_pop",  int'(busy_o), 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    send_b(25); send_b(35); send_b(45); send_b(14);
    drain();

    // Randomized traffic with random consumer stalls
    fork
      begin
        fork
          begin
            for (int i = 0; i < 150; i++) begin
              repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
              send_a(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40));
            end
          end
          begin
            for (int j = 0; j < 150; j++) begin
              repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
              send_b(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40));
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          y_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    y_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
